// File: rtl/funct_generator_ctrl.sv
// -----------------------------------------------------------------------------
// funct_generator_ctrl
//
// Sequencer for a waveform LUT. A phase accumulator supplies the LUT read
// address (top ADDR_WIDTH bits of the phase). The LUT has a one-cycle
// registered read, so every sample takes two states: FETCH, which presents the
// address, and PUSH, which forwards the returned word to the downstream FIFO.
// A run produces a programmed number of samples. A count of 0 runs
// continuously until stop_i is asserted.
//
// Ports
//   clk            system clock, all logic on the rising edge
//   rst            asynchronous reset, active-high
//   start_i        start a run (honoured in IDLE only)
//   stop_i         abort the run in progress
//   step_i         phase increment, latched at start
//   num_samples_i  samples per run, latched at start; 0 = continuous
//   lut_addr_o     LUT read address (phase MSBs)
//   lut_data_i     LUT read data, valid one cycle after lut_addr_o
//   fifo_full_i    FIFO full; suppresses fifo_wr_o
//   fifo_wr_o      FIFO write strobe (combinational)
//   fifo_data_o    FIFO write data; lut_data_i in PUSH, otherwise 0
//   busy_o         high whenever the sequencer is not in IDLE
//   done_o         one-cycle pulse at the end of a run
// -----------------------------------------------------------------------------
module funct_generator_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int PHASE_WIDTH = 16,   // must be >= ADDR_WIDTH
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic                   stop_i,
    input  logic [PHASE_WIDTH-1:0] step_i,
    input  logic [CNT_WIDTH-1:0]   num_samples_i,
    output logic [ADDR_WIDTH-1:0]  lut_addr_o,
    input  logic [DATA_WIDTH-1:0]  lut_data_i,
    input  logic                   fifo_full_i,
    output logic                   fifo_wr_o,
    output logic [DATA_WIDTH-1:0]  fifo_data_o,
    output logic                   busy_o,
    output logic                   done_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_PUSH  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [PHASE_WIDTH-1:0] phase_q, phase_d;
    logic [PHASE_WIDTH-1:0] step_q,  step_d;
    logic [CNT_WIDTH-1:0]   cnt_q,   cnt_d;
    logic [CNT_WIDTH-1:0]   num_q,   num_d;

    logic [CNT_WIDTH-1:0]   cnt_inc;
    logic                   count_hit;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        num_d   = num_q;

        cnt_inc   = cnt_q + CNT_WIDTH'(1);
        // num_q == 0 means continuous: the counter is allowed to wrap and
        // never ends the run.
        count_hit = (num_q != '0) && (cnt_inc == num_q);

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    phase_d = '0;
                    cnt_d   = '0;
                    step_d  = step_i;
                    num_d   = num_samples_i;
                    state_d = S_FETCH;
                end
            end

            // Address is held this cycle so the LUT can register the sample.
            S_FETCH: begin
                state_d = stop_i ? S_DONE : S_PUSH;
            end

            S_PUSH: begin
                if (!fifo_full_i) begin
                    // The write is committed on this edge; advance the phase
                    // so the next FETCH addresses the following sample.
                    phase_d = phase_q + step_q;
                    cnt_d   = cnt_inc;
                    state_d = (count_hit || stop_i) ? S_DONE : S_FETCH;
                end else if (stop_i) begin
                    state_d = S_DONE;
                end
                // Full without stop: phase is untouched, so the same sample
                // is retried next cycle with no drop and no duplicate.
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            step_q  <= '0;
            cnt_q   <= '0;
            num_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
        end
    end

    assign lut_addr_o  = phase_q[PHASE_WIDTH-1 -: ADDR_WIDTH];
    assign fifo_wr_o   = (state_q == S_PUSH) && !fifo_full_i;
    assign fifo_data_o = (state_q == S_PUSH) ? lut_data_i : '0;
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE);

endmodule
